// File: rtl/pcm_out_fifo.sv
// rtl/pcm_out_fifo.sv - FWFT output FIFO behind the CIC decimator with overflow tracking.
// Optional PCM_SIGNED_EN: read path converts offset-binary words to two's complement.
module pcm_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             mclk1,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [15:0]      drop_count,
  input  logic             clear_ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] head;
  logic             pop;
  logic             push;
  logic             drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = data_en & (~full | pop);
  assign drop      = data_en & full & ~pop;

  assign head = mem[rd_ptr[AW-1:0]];

`ifdef PCM_SIGNED_EN
  assign out_data = {~head[WIDTH-1], head[WIDTH-2:0]};
`else
  assign out_data = head;
`endif

  always_ff @(posedge mclk1) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge mclk1) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop in the same cycle as clear_ovf restarts the count at one.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf) begin
        drop_count <= 16'h0001;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'h0001;
      end
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_pcm_out_fifo.sv
// tb/tb_pcm_out_fifo.sv - self-checking bench for pcm_out_fifo against a queue model.
module tb_pcm_out_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             mclk1 = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_en;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [15:0]      drop_count;
  logic             clear_ovf;

  pcm_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .mclk1      (mclk1),
    .reset      (reset),
    .data_in    (data_in),
    .data_en    (data_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clear_ovf  (clear_ovf)
  );

  always #5 mclk1 = ~mclk1;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf;
  int               m_drops;

  function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] w);
`ifdef PCM_SIGNED_EN
    return w ^ 16'h8000;
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("level", 32'(level), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(conv(q[0])));
  endtask

  task automatic step(input logic en, input logic [WIDTH-1:0] din, input logic rdy, input logic clr);
    bit pop_m, full_m;
    data_en = en; data_in = din; out_ready = rdy; clear_ovf = clr;
    @(posedge mclk1);
    if (reset) begin
      q.delete(); m_ovf = 1'b0; m_drops = 0;
    end else begin
      pop_m  = (q.size() > 0) && rdy;
      full_m = (q.size() == DEPTH);
      if (pop_m) void'(q.pop_front());
      if (clr) begin m_ovf = 1'b0; m_drops = 0; end
      if (en) begin
        if (full_m && !pop_m) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          q.push_back(din);
        end
      end
    end
    @(negedge mclk1);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 3 * DEPTH) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check("drain_bound", 32'(q.size()), 32'd0);
  endtask

  initial begin
    data_en = 0; data_in = 0; out_ready = 0; clear_ovf = 0; reset = 1;
    m_ovf = 0; m_drops = 0;
    @(negedge mclk1);
    do_reset();
    do_reset();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);

    // single word in, single word out
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("single_data", 32'(out_data), 32'(conv(16'h1234)));
    check("single_level", 32'(level), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_popped", 32'(out_valid), 32'd0);

    // fill 0..15 and drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    drain();
    check("drain_empty", 32'(empty), 32'd1);

    // overflow by three then clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(drop_count), 32'd3);
    check("ovf_head", 32'(out_data), 32'(conv(16'h0000)));
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_count", 32'(drop_count), 32'd0);

    // simultaneous push and pop while full
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    check("full_pp_level", 32'(level), 32'd16);
    check("full_pp_nodrop", 32'(drop_count), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("aaaa_last", 32'(out_data), 32'(conv(16'hAAAA)));
    drain();

    // clear and drop in the same cycle
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i + 100), 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    step(1'b1, 16'h5556, 1'b0, 1'b0);
    step(1'b1, 16'h5557, 1'b0, 1'b1);
    check("clr_drop_flag", 32'(overflow), 32'd1);
    check("clr_drop_count", 32'(drop_count), 32'd1);
    drain();

    // reset mid-stream at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 7), 1'b0, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    do_reset();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);

    // offset-binary conversion corners
    step(1'b1, 16'h8000, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0);
`ifdef PCM_SIGNED_EN
    check("sgn_8000", 32'(out_data), 32'h0000);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sgn_ffff", 32'(out_data), 32'h7FFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("sgn_0000", 32'(out_data), 32'h8000);
`else
    check("raw_8000", 32'(out_data), 32'h8000);
    step(1'b0, '0, 1'b1, 1'b0);
    check("raw_ffff", 32'(out_data), 32'hFFFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("raw_0000", 32'(out_data), 32'h0000);
`endif
    drain();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      step(1'(($urandom_range(0, 99) < 55)), 16'($urandom),
           1'(($urandom_range(0, 99) < 45)), 1'(($urandom_range(0, 49) == 0)));
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
